// File: rtl/clock_pkg.sv
// Shared encodings and field limits for the clock mode controller.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package clock_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SET_H = 2'd1,
        ST_SET_M = 2'd2,
        ST_SET_S = 2'd3
    } state_t;

    localparam logic [5:0] HOURS_MAX   = 6'd23;
    localparam logic [5:0] MINUTES_MAX = 6'd59;
    localparam logic [5:0] SECONDS_MAX = 6'd59;

    // Increment a time field, wrapping to zero past its maximum.
    function automatic logic [5:0] inc_wrap(input logic [5:0] val, input logic [5:0] max);
        return (val >= max) ? 6'd0 : val + 6'd1;
    endfunction

    // Mode button cycles RUN -> SET_H -> SET_M -> SET_S -> RUN.
    function automatic state_t next_mode(input state_t s);
        case (s)
            ST_RUN:   return ST_SET_H;
            ST_SET_H: return ST_SET_M;
            ST_SET_M: return ST_SET_S;
            default:  return ST_RUN;
        endcase
    endfunction

    // Field-select LEDs {hours, minutes, seconds}; dark in RUN.
    function automatic logic [2:0] led_sel(input state_t s);
        case (s)
            ST_SET_H: return 3'b100;
            ST_SET_M: return 3'b010;
            ST_SET_S: return 3'b001;
            default:  return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/btn_repeat.sv
// Rising-edge detector with hold-to-repeat for a debounced button.
// Latency: inc_o is combinational from btn_i against registered history (same-cycle pulse).
// Backpressure: none; pulses are single-cycle and never queued.
module btn_repeat #(
    parameter logic [23:0] REPEAT_DELAY  = 24'd5_000_000,
    parameter logic [23:0] REPEAT_PERIOD = 24'd2_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic inc_o
);

    logic        btn_q;
    logic [23:0] hold_cnt_q;
    logic        repeating_q;
    logic [23:0] hold_cnt_d;
    logic [23:0] target;
    logic        rise;
    logic        fire;

    // Until the first repeat we wait the long delay, afterwards the short period.
    assign target = repeating_q ? REPEAT_PERIOD : REPEAT_DELAY;
    assign rise   = btn_i & ~btn_q;
    assign fire   = btn_i & btn_q & (hold_cnt_q == target);
    assign inc_o  = rise | fire;

    // hold_cnt_q equals the number of cycles since the press (or last repeat).
    always_comb begin
        hold_cnt_d = hold_cnt_q + 24'd1;
        if (!btn_i) begin
            hold_cnt_d = 24'd0;
        end else if (rise || fire) begin
            hold_cnt_d = 24'd1;
        end
    end

    // Button history, hold counter and repeat phase; release returns to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q       <= 1'b0;
            hold_cnt_q  <= 24'd0;
            repeating_q <= 1'b0;
        end else begin
            btn_q      <= btn_i;
            hold_cnt_q <= hold_cnt_d;
            if (!btn_i || rise) begin
                repeating_q <= 1'b0;
            end else if (fire) begin
                repeating_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clock_mode_ctrl.sv
// Time-of-day counter with a 4-state edit FSM, auto-repeat increment and edit timeout.
// Latency: every output is registered and reflects a tick/increment/mode edge one clk later.
// Backpressure: none; inputs are level/pulse signals sampled every clk.
module clock_mode_ctrl
    import clock_pkg::*;
#(
    parameter logic [23:0] REPEAT_DELAY  = 24'd5_000_000,
    parameter logic [23:0] REPEAT_PERIOD = 24'd2_500_000,
    parameter logic [3:0]  TIMEOUT_TICKS = 4'd10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       led_hours,
    output logic       led_minutes,
    output logic       led_seconds,
    output logic       blink
);

    state_t     state_q;
    logic [4:0] hours_q;
    logic [5:0] minutes_q;
    logic [5:0] seconds_q;
    logic [2:0] led_q;
    logic       blink_q;
    logic [3:0] timeout_q;
    logic       mode_prev_q;

    state_t     next_state_d;
    logic [4:0] hours_inc_d;
    logic [5:0] minutes_inc_d;
    logic [5:0] seconds_inc_d;
    logic [3:0] timeout_inc_d;
    logic       mode_edge;
    logic       inc_pulse;

    btn_repeat #(
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_btn_repeat (
        .clk   (clk),
        .rst   (rst),
        .btn_i (btn_inc),
        .inc_o (inc_pulse)
    );

    assign mode_edge = btn_mode & ~mode_prev_q;

    // Wrapped successor of every field plus the next mode, shared by run and edit paths.
    always_comb begin
        next_state_d  = next_mode(state_q);
        hours_inc_d   = 5'(inc_wrap({1'b0, hours_q}, HOURS_MAX));
        minutes_inc_d = inc_wrap(minutes_q, MINUTES_MAX);
        seconds_inc_d = inc_wrap(seconds_q, SECONDS_MAX);
        timeout_inc_d = timeout_q + 4'd1;
    end

    // Mode FSM, time registers, blink phase and edit timeout in one registered block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            hours_q     <= 5'd0;
            minutes_q   <= 6'd0;
            seconds_q   <= 6'd0;
            led_q       <= 3'b000;
            blink_q     <= 1'b0;
            timeout_q   <= 4'd0;
            mode_prev_q <= 1'b0;
        end else begin
            mode_prev_q <= btn_mode;

            // Time only runs in RUN; the edit states freeze it.
            if (state_q == ST_RUN && tick_1hz) begin
                if (seconds_q >= SECONDS_MAX) begin
                    seconds_q <= 6'd0;
                    if (minutes_q >= MINUTES_MAX) begin
                        minutes_q <= 6'd0;
                        hours_q   <= hours_inc_d;
                    end else begin
                        minutes_q <= minutes_inc_d;
                    end
                end else begin
                    seconds_q <= seconds_inc_d;
                end
            end

            if (mode_edge) begin
                // Mode edge beats a coincident increment, which is simply dropped.
                state_q   <= next_state_d;
                led_q     <= led_sel(next_state_d);
                blink_q   <= (next_state_d != ST_RUN);
                timeout_q <= 4'd0;
            end else if (state_q != ST_RUN) begin
                if (tick_1hz) begin
                    blink_q <= ~blink_q;
                end
                if (inc_pulse) begin
                    // Edits wrap the selected field alone, no carry.
                    timeout_q <= 4'd0;
                    case (state_q)
                        ST_SET_H: hours_q   <= hours_inc_d;
                        ST_SET_M: minutes_q <= minutes_inc_d;
                        ST_SET_S: seconds_q <= seconds_inc_d;
                        default:  ;
                    endcase
                end else if (tick_1hz) begin
                    if (timeout_inc_d == TIMEOUT_TICKS) begin
                        state_q   <= ST_RUN;
                        led_q     <= 3'b000;
                        blink_q   <= 1'b0;
                        timeout_q <= 4'd0;
                    end else begin
                        timeout_q <= timeout_inc_d;
                    end
                end
            end
        end
    end

    assign hours       = hours_q;
    assign minutes     = minutes_q;
    assign seconds     = seconds_q;
    assign led_hours   = led_q[2];
    assign led_minutes = led_q[1];
    assign led_seconds = led_q[0];
    assign blink       = blink_q;

endmodule
